instruction_loader: RTL and testbench
=====================================

# instruction_loader

Boot-time image loader that writes a program into the instruction memory before the single-cycle processor starts fetching. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and issues one-cycle write strobes to the instruction memory's write port. It verifies an XOR checksum and holds the processor in reset until the image is complete and valid.

## Interface

Parameters:
- MAX_WORDS, 256, instruction memory capacity in 32-bit words; a header count above this is an error.
- ADDR_WIDTH, 64, width of imem_address, matching the processor PC width.

Ports:
- clock  input  1  single clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high; returns the block to header-wait.
- rx_data  input  8  incoming stream byte.
- rx_valid  input  1  rx_data holds a byte.
- rx_ready  output  1  loader can accept a byte; a transfer occurs on an edge where rx_valid && rx_ready.
- imem_write  output  1  one-cycle write strobe to instruction memory.
- imem_address  output  ADDR_WIDTH  byte address of the write, always 4 × word index.
- imem_write_data  output  32  instruction word to write.
- cpu_reset  output  1  drives processor reset; high until a valid image is loaded.
- done  output  1  sticky; image loaded and checksum matched.
- error  output  1  sticky; count overflow or checksum mismatch.

## Operation

- Stream format: count_lo, count_hi (16-bit word count N, little-endian), then 4N instruction bytes, then 1 checksum byte.
- Instruction bytes are little-endian: the first byte of each group goes to imem_write_data[7:0], the fourth to [31:24].
- Checksum is the XOR of all 4N instruction bytes, starting from 0x00. Count bytes are excluded.
- States:
  - COUNT_LO: accept count_lo, go to COUNT_HI.
  - COUNT_HI: accept count_hi. If N > MAX_WORDS, go to ERROR. If N = 0, go to CHECK. Otherwise go to DATA.
  - DATA: accept bytes. On the 4th byte of a word, issue a write. After the 4th byte of word N−1, go to CHECK.
  - CHECK: accept the checksum byte. On a match go to DONE, otherwise go to ERROR.
  - DONE: done=1, cpu_reset=0. The block stays here until reset.
  - ERROR: error=1, cpu_reset=1. The block stays here until reset.
- rx_ready is 1 in COUNT_LO, COUNT_HI, DATA and CHECK, and 0 in DONE and ERROR. Bytes presented in DONE or ERROR are never consumed.
- The loader never stalls on writes. Writes are fire-and-forget, and the memory must accept one write per cycle.
- The word index counter is 16 bits and never wraps, because N ≤ MAX_WORDS ≤ 65535.
- imem_address is the zero-extended value of word_index << 2.

## Timing

- Reset values, visible in the cycle after any edge with reset=1:
  - rx_ready=1 (state COUNT_LO)
  - imem_write=0
  - imem_address=0
  - imem_write_data=0
  - cpu_reset=1
  - done=0
  - error=0
- Reset takes priority over a simultaneous transfer; that byte is dropped.
- Write latency: if the 4th byte of word k transfers on edge t, then in the cycle after t imem_write=1, imem_address=4k, and imem_write_data holds the assembled word. imem_write returns to 0 on the next edge unless another word completes.
- imem_address and imem_write_data hold their last values when imem_write=0.
- Header overflow: error=1 and rx_ready=0 in the cycle after the count_hi transfer.
- Checksum: if the checksum byte transfers on edge t, then in the cycle after t either done=1 and cpu_reset=0, or error=1 with cpu_reset staying 1.
- Back-to-back transfers are sustained at one byte per cycle with no bubbles. Idle cycles (rx_valid=0) leave all state unchanged.
- Reset mid-load:
  - The partial word, checksum and index are discarded, and the block returns to COUNT_LO.
  - Memory words already written are not cleared.
  - cpu_reset stays 1 throughout.

## Test plan

- Nominal image. Bytes 02 00 93 00 50 00 13 01 10 00 C1, streamed back-to-back. Required response:
  - Write at addr 0x0 with data 0x00500093, then write at addr 0x4 with data 0x00100113.
  - done=1 and cpu_reset=0 in the cycle after C1.
  - rx_ready=0 thereafter.
- Bad checksum. Same stream ending in C0 → both writes still occur, then error=1, done=0, cpu_reset=1, rx_ready=0. Extra bytes offered afterwards are not consumed.
- Empty image. Bytes 00 00 00 → no imem_write pulses, done=1, cpu_reset=0.
- Overflow. With MAX_WORDS=256, bytes 01 01 → error=1 in the cycle after the second byte, no writes, rx_ready=0.
- Throttled source. Nominal stream with 3 idle cycles (rx_valid=0) between every byte → identical writes and final state to the nominal case. Each write pulse is exactly one cycle wide.
- Reset mid-load. Assert reset for one cycle after the 5th data byte of the nominal stream, with rx_valid=1 on that edge. Required response:
  - All outputs return to their reset values and the byte on the reset edge is dropped.
  - Re-sending the full nominal stream then yields the same two writes and done=1.

Source files
------------

// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - boot loader: byte stream to 32-bit imem writes with XOR checksum gate
module instruction_loader #(
    parameter int MAX_WORDS  = 256,
    parameter int ADDR_WIDTH = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  imem_write,
    output logic [ADDR_WIDTH-1:0] imem_address,
    output logic [31:0]           imem_write_data,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {COUNT_LO, COUNT_HI, DATA, CHECK, DONE, ERROR} state_t;

    localparam logic [16:0] MAX_COUNT = 17'(MAX_WORDS);

    state_t      state;
    logic [7:0]  count_lo;
    logic [15:0] word_count;
    logic [15:0] word_index;
    logic [1:0]  byte_sel;
    logic [23:0] partial;
    logic [7:0]  checksum;
    logic        transfer;
    logic [15:0] header_count;

    assign transfer     = rx_valid && rx_ready;
    assign header_count = {rx_data, count_lo};

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= COUNT_LO;
            rx_ready        <= 1'b1;
            imem_write      <= 1'b0;
            imem_address    <= '0;
            imem_write_data <= '0;
            cpu_reset       <= 1'b1;
            done            <= 1'b0;
            error           <= 1'b0;
            count_lo        <= '0;
            word_count      <= '0;
            word_index      <= '0;
            byte_sel        <= '0;
            partial         <= '0;
            checksum        <= '0;
        end else begin
            imem_write <= 1'b0;
            if (transfer) begin
                case (state)
                    COUNT_LO: begin
                        count_lo <= rx_data;
                        state    <= COUNT_HI;
                    end
                    COUNT_HI: begin
                        word_count <= header_count;
                        if ({1'b0, header_count} > MAX_COUNT) begin
                            state    <= ERROR;
                            rx_ready <= 1'b0;
                            error    <= 1'b1;
                        end else if (header_count == 16'd0) begin
                            state <= CHECK;
                        end else begin
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        checksum <= checksum ^ rx_data;
                        byte_sel <= byte_sel + 2'd1;
                        // Bytes shift in from the top so the oldest lands in [7:0]
                        if (byte_sel == 2'd3) begin
                            imem_write      <= 1'b1;
                            imem_address    <= ADDR_WIDTH'({word_index, 2'b00});
                            imem_write_data <= {rx_data, partial};
                            word_index      <= word_index + 16'd1;
                            if (word_index == word_count - 16'd1) begin
                                state <= CHECK;
                            end
                        end else begin
                            partial <= {rx_data, partial[23:8]};
                        end
                    end
                    CHECK: begin
                        rx_ready <= 1'b0;
                        if (rx_data == checksum) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            state <= ERROR;
                            error <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// tb/tb_instruction_loader.sv - randomized bench with byte-position reference model for instruction_loader
module tb_instruction_loader;

    localparam int MAX_WORDS  = 256;
    localparam int ADDR_WIDTH = 64;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic [7:0]            rx_data = 8'h00;
    logic                  rx_valid = 1'b0;
    logic                  rx_ready;
    logic                  imem_write;
    logic [ADDR_WIDTH-1:0] imem_address;
    logic [31:0]           imem_write_data;
    logic                  cpu_reset;
    logic                  done;
    logic                  error;

    instruction_loader #(.MAX_WORDS(MAX_WORDS), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .imem_write     (imem_write),
        .imem_address   (imem_address),
        .imem_write_data(imem_write_data),
        .cpu_reset      (cpu_reset),
        .done           (done),
        .error          (error)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b1;

    // Model state: 0 loading, 1 done, 2 error
    int          m_pos, m_n, m_status;
    logic [7:0]  m_csum;
    logic [31:0] m_acc;
    logic        m_write;
    logic [63:0] m_addr;
    logic [31:0] m_data;

    logic [63:0] wr_addr[$];
    logic [31:0] wr_data[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Interprets each accepted byte by its position in the stream
    always @(posedge clock) begin
        m_write = 1'b0;
        if (reset) begin
            m_pos = 0; m_n = 0; m_status = 0; m_csum = 8'h00; m_acc = 32'h0;
            m_addr = 64'h0; m_data = 32'h0;
        end else if (rx_valid && m_status == 0) begin
            if (m_pos == 0) begin
                m_n = int'(rx_data);
            end else if (m_pos == 1) begin
                m_n = m_n + int'(rx_data) * 256;
                if (m_n > MAX_WORDS) m_status = 2;
            end else if (m_pos < 2 + 4 * m_n) begin
                int idx;
                idx = m_pos - 2;
                m_acc[(idx % 4) * 8 +: 8] = rx_data;
                m_csum = m_csum ^ rx_data;
                if (idx % 4 == 3) begin
                    m_write = 1'b1;
                    m_addr  = 64'((idx / 4) * 4);
                    m_data  = m_acc;
                end
            end else begin
                m_status = (rx_data == m_csum) ? 1 : 2;
            end
            m_pos++;
        end
    end

    always @(negedge clock) begin
        if (check_en) begin
            chk("rx_ready", 64'(rx_ready), 64'(m_status == 0));
            chk("done", 64'(done), 64'(m_status == 1));
            chk("error", 64'(error), 64'(m_status == 2));
            chk("cpu_reset", 64'(cpu_reset), 64'(m_status != 1));
            chk("imem_write", 64'(imem_write), 64'(m_write));
            chk("imem_address", imem_address, m_addr);
            chk("imem_write_data", 64'(imem_write_data), 64'(m_data));
            if (imem_write === 1'b1) begin
                wr_addr.push_back(imem_address);
                wr_data.push_back(imem_write_data);
            end
        end
    end

    task automatic do_reset();
        reset    = 1'b1;
        rx_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic send(input logic [7:0] b, input int idle);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clock);
        rx_valid = 1'b0;
        repeat (idle) @(negedge clock);
    endtask

    task automatic send_nominal(input int idle, input logic [7:0] cs);
        logic [7:0] img[10];
        img = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00};
        foreach (img[i]) send(img[i], idle);
        send(cs, idle);
    endtask

    task automatic check_nominal_writes(input string tag);
        chk({tag, "_nwrites"}, 64'(wr_addr.size()), 64'd2);
        if (wr_addr.size() == 2) begin
            chk({tag, "_addr0"}, wr_addr[0], 64'h0);
            chk({tag, "_data0"}, 64'(wr_data[0]), 64'h00500093);
            chk({tag, "_addr1"}, wr_addr[1], 64'h4);
            chk({tag, "_data1"}, 64'(wr_data[1]), 64'h00100113);
        end
    endtask

    initial begin
        @(negedge clock);
        reset = 1'b0;
        chk("reset_rx_ready", 64'(rx_ready), 64'd1);
        chk("reset_cpu_reset", 64'(cpu_reset), 64'd1);

        // Nominal image back-to-back, then extra bytes that must be ignored
        do_reset();
        send_nominal(0, 8'hC1);
        chk("nom_done", 64'(done), 64'd1);
        chk("nom_cpu_reset", 64'(cpu_reset), 64'd0);
        send(8'hAA, 0);
        send(8'h55, 1);
        chk("nom_rx_ready", 64'(rx_ready), 64'd0);
        check_nominal_writes("nom");

        // Bad checksum
        do_reset();
        send_nominal(0, 8'hC0);
        send(8'h12, 0);
        send(8'h34, 0);
        chk("bad_error", 64'(error), 64'd1);
        chk("bad_done", 64'(done), 64'd0);
        chk("bad_cpu_reset", 64'(cpu_reset), 64'd1);
        check_nominal_writes("bad");

        // Empty image
        do_reset();
        send(8'h00, 0); send(8'h00, 0); send(8'h00, 2);
        chk("empty_done", 64'(done), 64'd1);
        chk("empty_nwrites", 64'(wr_addr.size()), 64'd0);

        // Header overflow: N = 257
        do_reset();
        send(8'h01, 0);
        send(8'h01, 0);
        chk("ovf_error", 64'(error), 64'd1);
        chk("ovf_rx_ready", 64'(rx_ready), 64'd0);
        send(8'h00, 3);
        chk("ovf_nwrites", 64'(wr_addr.size()), 64'd0);

        // Throttled source
        do_reset();
        send_nominal(3, 8'hC1);
        chk("thr_done", 64'(done), 64'd1);
        check_nominal_writes("thr");

        // Reset mid-load after the 5th data byte, with a byte on the reset edge
        do_reset();
        begin
            logic [7:0] part[7];
            part = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13};
            foreach (part[i]) send(part[i], 0);
        end
        reset    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h01;
        @(negedge clock);
        reset    = 1'b0;
        rx_valid = 1'b0;
        chk("mid_imem_write", 64'(imem_write), 64'd0);
        chk("mid_imem_address", imem_address, 64'h0);
        chk("mid_imem_data", 64'(imem_write_data), 64'h0);
        chk("mid_rx_ready", 64'(rx_ready), 64'd1);
        chk("mid_cpu_reset", 64'(cpu_reset), 64'd1);
        wr_addr.delete();
        wr_data.delete();
        send_nominal(0, 8'hC1);
        chk("mid_done", 64'(done), 64'd1);
        check_nominal_writes("mid");

        // Randomized images, throttling and corruption
        for (int r = 0; r < 40; r++) begin
            int n;
            logic [7:0] cs, b;
            do_reset();
            n = $urandom_range(0, 6);
            if ($urandom_range(0, 9) == 0) n = 257 + $urandom_range(0, 5);
            send(8'(n), $urandom_range(0, 2));
            send(8'(n >> 8), $urandom_range(0, 2));
            cs = 8'h00;
            if (n <= MAX_WORDS) begin
                for (int k = 0; k < 4 * n; k++) begin
                    b = 8'($urandom);
                    cs = cs ^ b;
                    send(b, $urandom_range(0, 2));
                end
                if ($urandom_range(0, 3) == 0) cs = cs ^ (8'h01 << $urandom_range(0, 7));
                send(cs, $urandom_range(0, 2));
                chk("rnd_nwrites", 64'(wr_addr.size()), 64'(n));
            end
            send(8'($urandom), 0);
            send(8'($urandom), 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
